battle_board_engine: RTL
========================

Name: battle_board_engine

Overview:
Parametrised game-state engine holding every player's BOARD_SIZE x BOARD_SIZE board, with 2-bit cells: 00 water, 01 ship, 10 miss, 11 hit.
- Places ships in a setup phase, then arbitrates turns.
- Resolves shots through a valid/ready handshake and reports hit/miss/repeat/invalid.
- Tracks remaining ship cells and declares a winner.
- Sits between the keyboard decode path (fire requests) and the VGA/HEX controllers (registered cell read port, turn, winner).

Parameters:
BOARD_SIZE, 10, rows and columns per board (2..16)
NUM_PLAYERS, 2, number of players (2..4); shots always target player (turn+1) mod NUM_PLAYERS
COORD_W, $clog2(BOARD_SIZE), row/column index width
PLAYER_W, max(1,$clog2(NUM_PLAYERS)), player index width
CNT_W, $clog2(BOARD_SIZE*BOARD_SIZE+1), ship-cell counter width

Ports:
clock50  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
new_game  in  1  one-cycle pulse: clear all boards and counters, enter SETUP; priority over every other input, in any state
place_valid  in  1  SETUP only: mark one cell as ship
place_player  in  PLAYER_W  board to write
place_row, place_col  in  COORD_W each  cell to write
start_game  in  1  pulse: leave SETUP when every player has at least one ship cell
fire_valid  in  1  shot request
fire_ready  out  1  high only in PLAY
fire_row, fire_col  in  COORD_W each  target cell
result_valid  out  1  one-cycle pulse per accepted shot
result_code  out  2  00 miss, 01 hit, 10 repeat, 11 invalid; held until next result
player_turn  out  PLAYER_W  current shooter
game_over  out  1  high in GAMEOVER
winner  out  PLAYER_W  valid while game_over
rd_player  in  PLAYER_W  read-port board select
rd_row, rd_col  in  COORD_W each  read-port cell select
rd_fog  in  1  when 1, ship cells (01) read as water (00)
rd_cell  out  2  registered cell value, 1-cycle latency
ships_left  out  NUM_PLAYERS*CNT_W  packed remaining ship cells per player, player 0 in LSBs

Behaviour:
- Reset: all cells 00, all counters 0, state SETUP. Outputs: fire_ready 0, result_valid 0, result_code 00, player_turn 0, game_over 0, winner 0, rd_cell 00.
- Reset asserted mid-operation aborts immediately; an in-flight shot produces no result.
- States: SETUP, PLAY, RESOLVE, REPORT, GAMEOVER.
- SETUP:
  - place_valid with row/col < BOARD_SIZE and player < NUM_PLAYERS writes 01 and increments that player's counter.
  - Out-of-range placement, or a placement onto an existing ship, is ignored with no count change.
  - start_game is evaluated on counters before any same-cycle placement; that placement is still applied.
  - start_game with any counter 0 is ignored. Otherwise go to PLAY with player_turn 0.
  - fire_valid is ignored in SETUP.
- PLAY: fire_ready=1. A shot is accepted in cycle N when fire_valid&&fire_ready; the row/col pair is captured.
- RESOLVE (cycle N+1): the target cell is read and written.
  - Out-of-range coordinate: code 11, no write.
  - 00: write 10, code 00.
  - 01: write 11, decrement counter, code 01.
  - 10 or 11: code 10, no write.
- REPORT (cycle N+2): result_valid=1.
  - Miss or hit: player_turn advances (wraps NUM_PLAYERS-1 -> 0).
  - Repeat or invalid: turn is unchanged.
  - If the target counter reached 0: go to GAMEOVER with winner=shooter; player_turn does not advance.
  - Otherwise return to PLAY in cycle N+3.
- fire_ready is low during RESOLVE, REPORT and GAMEOVER. Throughput is at most one shot per 3 cycles.
- GAMEOVER: all state is frozen; only new_game or reset leaves it.
- new_game: boards and counters clear on the next edge; outputs take their reset values; state becomes SETUP. An in-flight shot is discarded.
- Read port: rd_cell is valid one cycle after the address.
  - Out-of-range address returns 00.
  - A read in the same cycle as a write returns the pre-write value.
- Counters never underflow, because a decrement only occurs on a 01 cell.

Optional Feature:
Macro BATTLE_HIT_AGAIN_EN.
- Defined: a hit that does not end the game keeps player_turn unchanged, so the shooter fires again.
- Undefined: player_turn advances on both hit and miss, as specified above.

Decomposition:
- Package battle_pkg:
  - cell encoding constants CELL_WATER/SHIP/MISS/HIT.
  - result codes RES_MISS/HIT/REPEAT/INVALID.
  - state enum typedef.
- One sub-module, battle_board_ram: per-player cell array with one write port, one internal resolve read port and one registered display read port.
- The FSM, counters and turn logic stay in the top.

Test Plan:
- Reset, then read every cell of both players -> rd_cell=00; fire_ready=0; player_turn=0.
- Place P1 ship at (3,4), start_game, then P0 fires (3,4) -> result_valid at N+2 with code 01, P1 cell=11, ships_left[P1]=0, game_over=1, winner=0.
- P0 fires (0,0) on water -> code 00, cell=10, player_turn=1. Fire (0,0) again at P0's next turn -> code 10, turn unchanged.
- Fire (10,2) with BOARD_SIZE=10 -> code 11, no write, turn unchanged. start_game with P1 count 0 -> state stays SETUP.
- NUM_PLAYERS=3, three misses -> turn sequence 0,1,2,0, each shot targeting the next player. rd_fog=1 on a ship cell -> 00; rd_fog=0 -> 01.
- Assert new_game in the RESOLVE cycle -> no result_valid, all cells 00, state SETUP. With BATTLE_HIT_AGAIN_EN, a non-final hit -> player_turn unchanged.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared encodings for the battle board engine: cell values, shot result codes,
// engine states and a range helper used for coordinate and player checks.
package battle_pkg;

   typedef logic [1:0] cell_t;
   localparam cell_t CELL_WATER = 2'b00;
   localparam cell_t CELL_SHIP  = 2'b01;
   localparam cell_t CELL_MISS  = 2'b10;
   localparam cell_t CELL_HIT   = 2'b11;

   typedef logic [1:0] res_t;
   localparam res_t RES_MISS    = 2'b00;
   localparam res_t RES_HIT     = 2'b01;
   localparam res_t RES_REPEAT  = 2'b10;
   localparam res_t RES_INVALID = 2'b11;

   typedef enum logic [2:0] {
      ST_SETUP,
      ST_PLAY,
      ST_RESOLVE,
      ST_REPORT,
      ST_GAMEOVER
   } state_t;

   // Index widths can hold values past the last board row or player, so every
   // address is checked against the real limit before it touches the array.
   function automatic logic below(input int unsigned v, input int unsigned lim);
      return v < lim;
   endfunction

endpackage

// File: rtl/battle_board_ram.sv
// Per-player cell storage: one write port, a combinational resolve read port for
// the engine, and a registered display read port with optional fog of war.
module battle_board_ram
   import battle_pkg::*;
#(
   parameter int BOARD_SIZE  = 10,
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = $clog2(BOARD_SIZE),
   parameter int PLAYER_W    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                clock50,
   input  logic                reset_n,
   input  logic                clear_i,
   input  logic                we_i,
   input  logic [PLAYER_W-1:0] wr_player_i,
   input  logic [COORD_W-1:0]  wr_row_i,
   input  logic [COORD_W-1:0]  wr_col_i,
   input  cell_t               wr_data_i,
   input  logic [PLAYER_W-1:0] rs_player_i,
   input  logic [COORD_W-1:0]  rs_row_i,
   input  logic [COORD_W-1:0]  rs_col_i,
   output cell_t               rs_cell_o,
   input  logic [PLAYER_W-1:0] rd_player_i,
   input  logic [COORD_W-1:0]  rd_row_i,
   input  logic [COORD_W-1:0]  rd_col_i,
   input  logic                rd_fog_i,
   output cell_t               rd_cell_o
);

   cell_t mem_q [NUM_PLAYERS][BOARD_SIZE][BOARD_SIZE];
   cell_t rd_q, rd_d;
   logic  wr_ok, rs_ok, rd_ok;

   assign wr_ok = below(32'(wr_player_i), NUM_PLAYERS) &&
                  below(32'(wr_row_i), BOARD_SIZE) && below(32'(wr_col_i), BOARD_SIZE);
   assign rs_ok = below(32'(rs_player_i), NUM_PLAYERS) &&
                  below(32'(rs_row_i), BOARD_SIZE) && below(32'(rs_col_i), BOARD_SIZE);
   assign rd_ok = below(32'(rd_player_i), NUM_PLAYERS) &&
                  below(32'(rd_row_i), BOARD_SIZE) && below(32'(rd_col_i), BOARD_SIZE);

   assign rs_cell_o = rs_ok ? mem_q[rs_player_i][rs_row_i][rs_col_i] : CELL_WATER;

   always_comb begin
      rd_d = CELL_WATER;
      if (rd_ok) begin
         rd_d = mem_q[rd_player_i][rd_row_i][rd_col_i];
         if (rd_fog_i && rd_d == CELL_SHIP) rd_d = CELL_WATER;
      end
   end

   // NOTE: the board is built from resettable flops rather than a RAM macro,
   // because new_game must wipe every cell of every player in a single edge.
   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            for (int r = 0; r < BOARD_SIZE; r++)
               for (int c = 0; c < BOARD_SIZE; c++)
                  mem_q[p][r][c] <= CELL_WATER;
         rd_q <= CELL_WATER;
      end else if (clear_i) begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            for (int r = 0; r < BOARD_SIZE; r++)
               for (int c = 0; c < BOARD_SIZE; c++)
                  mem_q[p][r][c] <= CELL_WATER;
         rd_q <= CELL_WATER;
      end else begin
         if (we_i && wr_ok) mem_q[wr_player_i][wr_row_i][wr_col_i] <= wr_data_i;
         rd_q <= rd_d;
      end
   end

   assign rd_cell_o = rd_q;

endmodule

// File: rtl/battle_board_engine.sv
// Battleship game-state engine: ship placement, turn arbitration, shot resolution
// and winner detection. Define BATTLE_HIT_AGAIN_EN to let a hitting shooter fire again.
module battle_board_engine
   import battle_pkg::*;
#(
   parameter int BOARD_SIZE  = 10,
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = $clog2(BOARD_SIZE),
   parameter int PLAYER_W    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
   parameter int CNT_W       = $clog2(BOARD_SIZE*BOARD_SIZE+1)
) (
   input  logic                         clock50,
   input  logic                         reset_n,
   input  logic                         new_game,
   input  logic                         place_valid,
   input  logic [PLAYER_W-1:0]          place_player,
   input  logic [COORD_W-1:0]           place_row,
   input  logic [COORD_W-1:0]           place_col,
   input  logic                         start_game,
   input  logic                         fire_valid,
   output logic                         fire_ready,
   input  logic [COORD_W-1:0]           fire_row,
   input  logic [COORD_W-1:0]           fire_col,
   output logic                         result_valid,
   output logic [1:0]                   result_code,
   output logic [PLAYER_W-1:0]          player_turn,
   output logic                         game_over,
   output logic [PLAYER_W-1:0]          winner,
   input  logic [PLAYER_W-1:0]          rd_player,
   input  logic [COORD_W-1:0]           rd_row,
   input  logic [COORD_W-1:0]           rd_col,
   input  logic                         rd_fog,
   output logic [1:0]                   rd_cell,
   output logic [NUM_PLAYERS*CNT_W-1:0] ships_left
);

   state_t              state_q, state_d;
   logic [PLAYER_W-1:0] turn_q, turn_d, winner_q, winner_d, tgt_player;
   logic [COORD_W-1:0]  shot_row_q, shot_row_d, shot_col_q, shot_col_d;
   res_t                code_q, code_d;
   logic [CNT_W-1:0]    cnt_q [NUM_PLAYERS];
   logic [CNT_W-1:0]    cnt_d [NUM_PLAYERS];

   logic [PLAYER_W-1:0] acc_player;
   logic [COORD_W-1:0]  acc_row, acc_col;
   cell_t               acc_cell, wr_data;
   logic                we, place_ok, shot_ok, all_ships, advance;

   assign tgt_player = (turn_q == PLAYER_W'(NUM_PLAYERS-1)) ? '0 : turn_q + 1'b1;

   // The board port serves placement in SETUP and the captured shot in RESOLVE.
   assign acc_player = (state_q == ST_RESOLVE) ? tgt_player : place_player;
   assign acc_row    = (state_q == ST_RESOLVE) ? shot_row_q : place_row;
   assign acc_col    = (state_q == ST_RESOLVE) ? shot_col_q : place_col;

   assign place_ok = (state_q == ST_SETUP) && place_valid &&
                     below(32'(place_player), NUM_PLAYERS) &&
                     below(32'(place_row), BOARD_SIZE) && below(32'(place_col), BOARD_SIZE) &&
                     (acc_cell != CELL_SHIP);
   assign shot_ok  = below(32'(shot_row_q), BOARD_SIZE) && below(32'(shot_col_q), BOARD_SIZE);

   always_comb begin
      all_ships = 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++)
         if (cnt_q[p] == '0) all_ships = 1'b0;
   end

`ifdef BATTLE_HIT_AGAIN_EN
   assign advance = (code_q == RES_MISS);
`else
   assign advance = (code_q == RES_MISS) || (code_q == RES_HIT);
`endif

   battle_board_ram #(
      .BOARD_SIZE (BOARD_SIZE),
      .NUM_PLAYERS(NUM_PLAYERS),
      .COORD_W    (COORD_W),
      .PLAYER_W   (PLAYER_W)
   ) u_ram (
      .clock50    (clock50),
      .reset_n    (reset_n),
      .clear_i    (new_game),
      .we_i       (we),
      .wr_player_i(acc_player),
      .wr_row_i   (acc_row),
      .wr_col_i   (acc_col),
      .wr_data_i  (wr_data),
      .rs_player_i(acc_player),
      .rs_row_i   (acc_row),
      .rs_col_i   (acc_col),
      .rs_cell_o  (acc_cell),
      .rd_player_i(rd_player),
      .rd_row_i   (rd_row),
      .rd_col_i   (rd_col),
      .rd_fog_i   (rd_fog),
      .rd_cell_o  (rd_cell)
   );

   // NOTE: all registers use non-blocking assignments so every _q samples the
   // same pre-edge _d values, independent of statement order.
   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SETUP;
         turn_q     <= '0;
         winner_q   <= '0;
         shot_row_q <= '0;
         shot_col_q <= '0;
         code_q     <= RES_MISS;
         for (int p = 0; p < NUM_PLAYERS; p++) cnt_q[p] <= '0;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         winner_q   <= winner_d;
         shot_row_q <= shot_row_d;
         shot_col_q <= shot_col_d;
         code_q     <= code_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      winner_d   = winner_q;
      shot_row_d = shot_row_q;
      shot_col_d = shot_col_q;
      code_d     = code_q;
      cnt_d      = cnt_q;
      we         = 1'b0;
      wr_data    = CELL_SHIP;
      if (new_game) begin
         state_d  = ST_SETUP;
         turn_d   = '0;
         winner_d = '0;
         code_d   = RES_MISS;
         for (int p = 0; p < NUM_PLAYERS; p++) cnt_d[p] = '0;
      end else begin
         case (state_q)
            ST_SETUP: begin
               // start_game looks at the counters before this cycle's placement.
               if (start_game && all_ships) begin
                  state_d = ST_PLAY;
                  turn_d  = '0;
               end
               if (place_ok) begin
                  we                  = 1'b1;
                  cnt_d[place_player] = cnt_q[place_player] + CNT_W'(1);
               end
            end
            ST_PLAY: begin
               if (fire_valid) begin
                  state_d    = ST_RESOLVE;
                  shot_row_d = fire_row;
                  shot_col_d = fire_col;
               end
            end
            ST_RESOLVE: begin
               state_d = ST_REPORT;
               if (!shot_ok) begin
                  code_d = RES_INVALID;
               end else if (acc_cell == CELL_WATER) begin
                  code_d  = RES_MISS;
                  we      = 1'b1;
                  wr_data = CELL_MISS;
               end else if (acc_cell == CELL_SHIP) begin
                  code_d            = RES_HIT;
                  we                = 1'b1;
                  wr_data           = CELL_HIT;
                  cnt_d[tgt_player] = cnt_q[tgt_player] - CNT_W'(1);
               end else begin
                  code_d = RES_REPEAT;
               end
            end
            ST_REPORT: begin
               if (cnt_q[tgt_player] == '0) begin
                  state_d  = ST_GAMEOVER;
                  winner_d = turn_q;
               end else begin
                  state_d = ST_PLAY;
                  if (advance) turn_d = tgt_player;
               end
            end
            ST_GAMEOVER: ;
            default: state_d = ST_SETUP;
         endcase
      end
   end

   always_comb begin
      fire_ready   = 1'b0;
      result_valid = 1'b0;
      game_over    = 1'b0;
      case (state_q)
         ST_PLAY:     fire_ready   = 1'b1;
         ST_REPORT:   result_valid = 1'b1;
         ST_GAMEOVER: game_over    = 1'b1;
         default: ;
      endcase
   end

   assign result_code = code_q;
   assign player_turn = turn_q;
   assign winner      = winner_q;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ships
      assign ships_left[p*CNT_W +: CNT_W] = cnt_q[p];
   end

endmodule
